// File: rtl/mdu_iter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_iter_if : EX-stage <-> multiply/divide unit connection bundle          |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start_e;
    logic [2:0]       op_e;
    logic [WIDTH-1:0] srca_e;
    logic [WIDTH-1:0] srcb_e;
    logic             hiloread_e;
    logic             abort_e;
    logic             busy;
    logic             done;
    logic             stall_mdu;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues operations and reads HI/LO
    modport master (
        output start_e, op_e, srca_e, srcb_e, hiloread_e, abort_e,
        input  busy, done, stall_mdu, hi, lo
    );

    modport slave (
        input  start_e, op_e, srca_e, srcb_e, hiloread_e, abort_e,
        output busy, done, stall_mdu, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_iter : radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    mdu_iter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_LOAD = WIDTH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] c_CNT_LAST = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_dz;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_done;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_ph;
    logic [WIDTH-1:0] r_pl;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_busy;
    logic             w_accept;
    logic             w_mdop;
    logic             w_sgn;
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    assign w_busy   = (r_state != c_IDLE);
    assign w_accept = (r_state == c_IDLE) && bus.start_e && !bus.abort_e;
    assign w_mdop   = !bus.op_e[2];
    assign w_sgn    = !bus.op_e[0];
    assign w_sa     = w_sgn && bus.srca_e[WIDTH-1];
    assign w_sb     = w_sgn && bus.srcb_e[WIDTH-1];
    // MIN maps onto itself, which is the correct unsigned magnitude 2^(WIDTH-1)
    assign w_mag_a  = w_sa ? -bus.srca_e : bus.srca_e;
    assign w_mag_b  = w_sb ? -bus.srcb_e : bus.srcb_e;

    // Multiply step: conditional add of the multiplicand into the upper half, then shift right
    assign w_sum    = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Divide step: shift next dividend bit into the partial remainder and trial-subtract
    assign w_shift  = {r_ph, r_pl[WIDTH-1]};
    assign w_ge     = (w_shift >= {1'b0, r_m});
    assign w_sub    = w_shift[WIDTH-1:0] - r_m;

    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
    // Zero divisor leaves the dividend magnitude in r_ph and all-ones in r_pl
    assign w_quo      = r_dz ? {WIDTH{1'b1}} : (r_neg_lo ? -r_pl : r_pl);
    assign w_rem      = r_neg_hi ? -r_ph : r_ph;
    assign w_fix_hi   = r_is_div ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_fix_lo   = r_is_div ? w_quo : w_prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_done   <= 1'b0;
            r_m      <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        if (w_mdop) begin
                            r_state  <= c_RUN;
                            r_cnt    <= c_CNT_LOAD;
                            r_is_div <= bus.op_e[1];
                            r_dz     <= bus.op_e[1] && (bus.srcb_e == '0);
                            r_neg_lo <= w_sa ^ w_sb;
                            r_neg_hi <= w_sa;
                            r_m      <= w_mag_b;
                            r_ph     <= '0;
                            r_pl     <= w_mag_a;
                        end else if (!bus.op_e[1]) begin
                            if (bus.op_e[0]) begin
                                r_lo <= bus.srca_e;
                            end else begin
                                r_hi <= bus.srca_e;
                            end
                        end
                    end
                end
                c_RUN: begin
                    if (bus.abort_e) begin
                        r_state <= c_IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_ph <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                            r_pl <= {r_pl[WIDTH-2:0], w_ge};
                        end else begin
                            r_ph <= w_sum[WIDTH:1];
                            r_pl <= {w_sum[0], r_pl[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt - c_CNT_LAST;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_FIX;
                        end
                    end
                end
                c_FIX: begin
                    r_state <= c_IDLE;
                    if (!bus.abort_e) begin
                        r_hi   <= w_fix_hi;
                        r_lo   <= w_fix_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.stall_mdu = w_busy && (bus.start_e || bus.hiloread_e);
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdu_iter : directed + random bench for mdu_iter at WIDTH=32 and WIDTH=8 |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_mdu_iter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_iter_if #(.WIDTH(32)) b32 ();
    mdu_iter_if #(.WIDTH(8))  b8 ();

    mdu_iter #(.WIDTH(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
    mdu_iter #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8));

    int n_err = 0;
    int n_chk = 0;
    bit sel8  = 1'b0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    logic [31:0] w_hi, w_lo;
    logic        w_busy, w_done, w_stall;
    always_comb begin
        w_hi    = sel8 ? {24'd0, b8.hi} : b32.hi;
        w_lo    = sel8 ? {24'd0, b8.lo} : b32.lo;
        w_busy  = sel8 ? b8.busy      : b32.busy;
        w_done  = sel8 ? b8.done      : b32.done;
        w_stall = sel8 ? b8.stall_mdu : b32.stall_mdu;
    end

    // Reference: plain integer arithmetic on WIDTH-bit values, returns {hi, lo}
    function automatic logic [63:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] mask, ua, ub, rh, rl;
        longint      sa, sb;
        logic [63:0] p;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = a_in & mask;
        ub = b_in & mask;
        sa = longint'(ua);
        if (ua[w-1]) sa = sa - (longint'(1) << w);
        sb = longint'(ub);
        if (ub[w-1]) sb = sb - (longint'(1) << w);
        if (op == 3'b000)      p = 64'(sa * sb);
        else if (op == 3'b001) p = 64'(ua) * 64'(ub);
        else                   p = '0;
        if (op[1]) begin
            if (ub == 0) begin
                rl = mask;
                rh = ua;
            end else if (op[0]) begin
                rl = ua / ub;
                rh = ua % ub;
            end else begin
                rl = 32'(sa / sb) & mask;
                rh = 32'(sa % sb) & mask;
            end
        end else begin
            rl = p[31:0] & mask;
            rh = 32'(p >> w) & mask;
        end
        return {rh, rl};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic hr, input logic ab);
        b32.start_e    = st & ~sel8;
        b32.op_e       = op;
        b32.srca_e     = a;
        b32.srcb_e     = b;
        b32.hiloread_e = hr & ~sel8;
        b32.abort_e    = ab & ~sel8;
        b8.start_e     = st & sel8;
        b8.op_e        = op;
        b8.srca_e      = a[7:0];
        b8.srcb_e      = b[7:0];
        b8.hiloread_e  = hr & sel8;
        b8.abort_e     = ab & sel8;
    endtask

    // Issues one arithmetic op at the next edge and checks timing and result.
    // With junk set, the stalled pipeline keeps presenting MTHI and MFHI while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit junk, input string tag);
        int w;
        logic [63:0] e;
        w = sel8 ? 8 : 32;
        e = ref_model(w, op, a, b);
        drv(1'b1, op, a, b, 1'b0, 1'b0);
        for (int cyc = 1; cyc <= w + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check({tag, " busy@1"}, 32'(w_busy), 32'd1);
                check({tag, " done@1"}, 32'(w_done), 32'd0);
            end
            if (junk && cyc == 2) check({tag, " stall@2"}, 32'(w_stall), 32'd1);
            if (cyc == w + 1) begin
                check({tag, " busy@fix"}, 32'(w_busy), 32'd1);
                check({tag, " done@fix"}, 32'(w_done), 32'd0);
                if (junk) check({tag, " stall@fix"}, 32'(w_stall), 32'd1);
            end
            if (cyc == w + 2) begin
                check({tag, " done"}, 32'(w_done), 32'd1);
                check({tag, " busy@done"}, 32'(w_busy), 32'd0);
                check({tag, " hi"}, w_hi, e[63:32]);
                check({tag, " lo"}, w_lo, e[31:0]);
                if (junk) check({tag, " stall@done"}, 32'(w_stall), 32'd0);
            end
            if (junk && cyc <= w)          drv(1'b1, 3'b100, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
            else if (junk && cyc == w + 1) drv(1'b0, op, a, b, 1'b1, 1'b0);
            else                           drv(1'b0, op, a, b, 1'b0, 1'b0);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
    endtask

    task automatic mt(input logic to_lo, input logic [31:0] v, input string tag);
        drv(1'b1, to_lo ? 3'b101 : 3'b100, v, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        if (to_lo) exp_lo = v;
        else       exp_hi = v;
        check({tag, " hi"}, w_hi, exp_hi);
        check({tag, " lo"}, w_lo, exp_lo);
        check({tag, " done"}, 32'(w_done), 32'd0);
        check({tag, " busy"}, 32'(w_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          seen_done;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          pick;

        drv(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst hi32",    b32.hi, 32'h0);
        check("rst lo32",    b32.lo, 32'h0);
        check("rst busy32",  32'(b32.busy), 32'd0);
        check("rst done32",  32'(b32.done), 32'd0);
        check("rst stall32", 32'(b32.stall_mdu), 32'd0);
        check("rst hi8",     32'(b8.hi), 32'h0);
        check("rst lo8",     32'(b8.lo), 32'h0);
        check("rst busy8",   32'(b8.busy), 32'd0);
        reset = 1'b1;

        run_op(3'b001, 32'hFFFF_FFFF, 32'h2, 1'b0, "multu max*2");
        run_op(3'b000, 32'hFFFF_FFFD, 32'h5, 1'b0, "mult -3*5");
        run_op(3'b010, 32'hFFFF_FFF9, 32'h2, 1'b1, "div -7/2 b2b");
        run_op(3'b011, 32'h0000_1234, 32'h0, 1'b0, "divu by0");
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1");
        run_op(3'b010, 32'hFFFF_FF00, 32'h0, 1'b0, "div neg by0");

        mt(1'b0, 32'hAAAA_0000, "mthi");
        mt(1'b1, 32'h0000_5555, "mtlo");

        // Abort in the middle of RUN leaves HI/LO alone and yields no done
        mt(1'b0, 32'h11, "mthi 11");
        mt(1'b1, 32'h22, "mtlo 22");
        drv(1'b1, 3'b001, 32'd7, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b0, 3'b001, 32'd7, 32'd9, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("abort busy@10", 32'(w_busy), 32'd1);
        drv(1'b0, 3'b001, 32'd7, 32'd9, 1'b0, 1'b1);
        @(negedge clk);
        drv(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        check("abort busy", 32'(w_busy), 32'd0);
        check("abort hi", w_hi, 32'h11);
        check("abort lo", w_lo, 32'h22);
        seen_done = 1'b0;
        repeat (36) begin
            @(negedge clk);
            if (w_done) seen_done = 1'b1;
        end
        check("abort no done", 32'(seen_done), 32'd0);

        drv(1'b1, 3'b001, 32'd7, 32'd9, 1'b0, 1'b1);
        @(negedge clk);
        drv(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        check("abort blocks start", 32'(w_busy), 32'd0);

        drv(1'b1, 3'b110, 32'h1234, 32'h5678, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b1, 3'b111, 32'h1234, 32'h5678, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reserved busy", 32'(w_busy), 32'd0);
        check("reserved hi", w_hi, 32'h11);
        check("reserved lo", w_lo, 32'h22);

        // Reset pulled low between clock edges mid-RUN
        drv(1'b1, 3'b001, 32'd7, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        drv(1'b0, 3'b001, 32'd7, 32'd9, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async rst hi", w_hi, 32'h0);
        check("async rst lo", w_lo, 32'h0);
        check("async rst busy", 32'(w_busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;

        sel8 = 1'b1;
        drv(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        run_op(3'b011, 32'd200, 32'd7, 1'b0, "w8 divu 200/7");
        run_op(3'b000, 32'h80, 32'h80, 1'b1, "w8 mult -128*-128");

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 10; k++) begin
                rop  = 3'($urandom_range(0, 3));
                ra   = $urandom;
                rb   = $urandom;
                pick = $urandom_range(0, 7);
                if (pick == 0) rb = 32'h0;
                if (pick == 1) begin
                    ra = sel8 ? 32'h80 : 32'h8000_0000;
                    rb = 32'hFFFF_FFFF;
                end
                if (pick == 2) rb = 32'($urandom_range(1, 5));
                run_op(rop, ra, rb, k[0], sel8 ? "w8 rand" : "w32 rand");
            end
            sel8 = 1'b0;
            drv(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
